// File: rtl/gba_lcd_capture.sv
// GBA LCD capture: synchronizes the GBA LCD bus into the system clock domain
// and writes each line of RGB555 pixels into one of two SRAM frame banks.
// The bank holding the last complete frame is reported for display.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_IDLE    | waiting for a frame start (VSYNC fall)
// S_WAIT    | frame armed, waiting for the start of a line (HSYNC fall)
// S_CAPTURE | writing one pixel per DCLK rise into the current line
// S_LINE_END| line finished, advance line index and line base
module gba_lcd_capture #(
   parameter int H_PIXELS    = 240,
   parameter int V_LINES     = 160,
   parameter int BANK_STRIDE = 38400
) (
   input  logic        IwClk,
   input  logic        IwReset,
   input  logic        IwDclk,
   input  logic        IwHsync,
   input  logic        IwVsync,
   input  logic [14:0] IbPixel,
   output logic [16:0] ObWriteAddress,
   output logic [15:0] ObData,
   output logic        OwWrite,
   output logic        OwDisplayBank,
   output logic        OwFrameValid,
   output logic        OwFrameDone,
   output logic [7:0]  ObDroppedFrames
);

   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = $clog2(V_LINES + 1);
   localparam logic [16:0]   STRIDE = 17'(BANK_STRIDE);
   localparam logic [16:0]   HSTEP  = 17'(H_PIXELS);
   localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_LINES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT     = 2'd1,
      S_CAPTURE  = 2'd2,
      S_LINE_END = 2'd3
   } state_t;

   // bit 0 = stage 1, bit 1 = stage 2, bit 2 = edge-detect reference
   logic [2:0]  dclk_sync_q;
   logic [2:0]  hs_sync_q;
   logic [2:0]  vs_sync_q;
   logic [14:0] pix_s1_q;
   logic [14:0] pix_s2_q;
   logic [14:0] pix_edge_q;
   logic        dclk_rise_q;
   logic        hs_fall_q;
   logic        vs_fall_q;

   state_t        state_q;
   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [16:0]   line_base_q;
   logic [16:0]   ptr_q;
   logic          cap_bank_q;

   logic [16:0]   bank_base_d;
   logic [16:0]   next_base_d;

   assign bank_base_d = cap_bank_q ? STRIDE : 17'd0;
   assign next_base_d = line_base_q + HSTEP;

   // Synchronize the LCD bus and register edge pulses, pixel kept aligned with DCLK
   always_ff @(posedge IwClk or posedge IwReset) begin
      if (IwReset) begin
         dclk_sync_q <= 3'b000;
         hs_sync_q   <= 3'b111;
         vs_sync_q   <= 3'b111;
         pix_s1_q    <= '0;
         pix_s2_q    <= '0;
         pix_edge_q  <= '0;
         dclk_rise_q <= 1'b0;
         hs_fall_q   <= 1'b0;
         vs_fall_q   <= 1'b0;
      end else begin
         dclk_sync_q <= {dclk_sync_q[1:0], IwDclk};
         hs_sync_q   <= {hs_sync_q[1:0], IwHsync};
         vs_sync_q   <= {vs_sync_q[1:0], IwVsync};
         pix_s1_q    <= IbPixel;
         pix_s2_q    <= pix_s1_q;
         pix_edge_q  <= pix_s2_q;
         dclk_rise_q <= dclk_sync_q[1] & ~dclk_sync_q[2];
         hs_fall_q   <= ~hs_sync_q[1] & hs_sync_q[2];
         vs_fall_q   <= ~vs_sync_q[1] & vs_sync_q[2];
      end
   end

   // Capture FSM with registered SRAM write port and frame status
   always_ff @(posedge IwClk or posedge IwReset) begin
      if (IwReset) begin
         state_q         <= S_IDLE;
         x_q             <= '0;
         y_q             <= '0;
         line_base_q     <= '0;
         ptr_q           <= '0;
         cap_bank_q      <= 1'b0;
         OwDisplayBank   <= 1'b1;
         OwFrameValid    <= 1'b0;
         OwWrite         <= 1'b0;
         OwFrameDone     <= 1'b0;
         ObWriteAddress  <= '0;
         ObData          <= '0;
         ObDroppedFrames <= '0;
      end else begin
         OwWrite     <= 1'b0;
         OwFrameDone <= 1'b0;
         if (vs_fall_q) begin
            // a frame start outranks any pixel or line event in the same cycle
            if (state_q != S_IDLE && ObDroppedFrames != 8'hFF)
               ObDroppedFrames <= ObDroppedFrames + 8'd1;
            state_q     <= S_WAIT;
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= bank_base_d;
         end else begin
            case (state_q)
               S_WAIT: begin
                  if (hs_fall_q) begin
                     state_q <= S_CAPTURE;
                     x_q     <= '0;
                     ptr_q   <= line_base_q;
                  end
               end
               S_CAPTURE: begin
                  if (hs_fall_q) begin
                     // short line: close it and start the next one immediately
                     y_q         <= y_q + 1'b1;
                     line_base_q <= next_base_d;
                     ptr_q       <= next_base_d;
                     x_q         <= '0;
                     if (y_q == Y_LAST) begin
                        OwDisplayBank <= cap_bank_q;
                        cap_bank_q    <= ~cap_bank_q;
                        OwFrameValid  <= 1'b1;
                        OwFrameDone   <= 1'b1;
                        state_q       <= S_IDLE;
                     end
                  end else if (dclk_rise_q) begin
                     OwWrite        <= 1'b1;
                     ObWriteAddress <= ptr_q;
                     ObData         <= {1'b0, pix_edge_q};
                     ptr_q          <= ptr_q + 17'd1;
                     x_q            <= x_q + 1'b1;
                     if (x_q == X_LAST)
                        state_q <= S_LINE_END;
                  end
               end
               S_LINE_END: begin
                  y_q         <= y_q + 1'b1;
                  line_base_q <= next_base_d;
                  if (y_q == Y_LAST) begin
                     OwDisplayBank <= cap_bank_q;
                     cap_bank_q    <= ~cap_bank_q;
                     OwFrameValid  <= 1'b1;
                     OwFrameDone   <= 1'b1;
                     state_q       <= S_IDLE;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gba_lcd_capture.sv
// Bench for gba_lcd_capture: directed frame sequence with random pixels,
// random short-line lengths and a frame-level reference model.
module tb_gba_lcd_capture;

   localparam int H = 240;
   localparam int V = 4;
   localparam int S = 38400;

   logic        clk = 1'b0;
   logic        rst;
   logic        dclk;
   logic        hs;
   logic        vs;
   logic [14:0] pix;
   logic [16:0] ObWriteAddress;
   logic [15:0] ObData;
   logic        OwWrite;
   logic        OwDisplayBank;
   logic        OwFrameValid;
   logic        OwFrameDone;
   logic [7:0]  ObDroppedFrames;

   gba_lcd_capture #(.H_PIXELS(H), .V_LINES(V), .BANK_STRIDE(S)) dut (
      .IwClk(clk), .IwReset(rst), .IwDclk(dclk), .IwHsync(hs), .IwVsync(vs),
      .IbPixel(pix), .ObWriteAddress(ObWriteAddress), .ObData(ObData),
      .OwWrite(OwWrite), .OwDisplayBank(OwDisplayBank), .OwFrameValid(OwFrameValid),
      .OwFrameDone(OwFrameDone), .ObDroppedFrames(ObDroppedFrames)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;
   int done_count = 0;

   // observed strobe totals
   always @(negedge clk) begin
      if (OwWrite) wr_count++;
      if (OwFrameDone) done_count++;
   end

   // reference model: frame-level view of where the next pixel belongs
   bit m_armed, m_in_line, m_bank, m_disp, m_valid;
   int m_line, m_x, m_drop, m_writes, m_dones;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic m_frame_complete();
      m_disp = m_bank;
      m_bank = ~m_bank;
      m_valid = 1'b1;
      m_armed = 1'b0;
      m_in_line = 1'b0;
      m_dones++;
   endtask

   task automatic m_line_end();
      m_line++;
      if (m_line == V) m_frame_complete();
   endtask

   task automatic m_vsync();
      if (m_armed && m_drop < 255) m_drop++;
      m_armed = 1'b1;
      m_line = 0;
      m_in_line = 1'b0;
   endtask

   task automatic m_reset();
      m_armed = 0; m_in_line = 0; m_bank = 0; m_disp = 1; m_valid = 0;
      m_drop = 0; m_line = 0; m_x = 0;
   endtask

   task automatic dclk_pulse(input logic [14:0] p, input bit with_vs);
      bit exp_wr;
      int exp_addr;
      exp_wr = m_armed && m_in_line && !with_vs;
      exp_addr = (m_bank ? S : 0) + m_line * H + m_x;
      pix = p;
      dclk = 1'b1;
      if (with_vs) vs = 1'b0;
      tick(3);
      check("wr_early", OwWrite, 0);
      tick(1);
      check("wr_strobe", OwWrite, exp_wr);
      if (exp_wr) begin
         check("wr_addr", ObWriteAddress, exp_addr);
         check("wr_data", ObData, {17'd0, p});
         m_writes++;
         m_x++;
         if (m_x == H) begin
            m_in_line = 1'b0;
            m_line_end();
         end
      end
      if (with_vs) m_vsync();
      dclk = 1'b0;
      tick(1);
      check("wr_one_cycle", OwWrite, 0);
      if (with_vs) vs = 1'b1;
      tick(3);
   endtask

   task automatic dclk_run(input int n);
      for (int i = 0; i < n; i++) dclk_pulse(15'($urandom), 1'b0);
   endtask

   task automatic hs_pulse();
      hs = 1'b0;
      tick(4);
      hs = 1'b1;
      tick(4);
      if (m_armed) begin
         if (m_in_line) begin
            m_line_end();
            if (m_armed) begin m_in_line = 1'b1; m_x = 0; end
         end else begin
            m_in_line = 1'b1;
            m_x = 0;
         end
      end
   endtask

   task automatic vs_pulse();
      vs = 1'b0;
      tick(4);
      vs = 1'b1;
      tick(4);
      m_vsync();
   endtask

   task automatic check_status(input string tag);
      check({tag, "_disp"}, OwDisplayBank, m_disp);
      check({tag, "_valid"}, OwFrameValid, m_valid);
      check({tag, "_drop"}, ObDroppedFrames, m_drop);
      check({tag, "_writes"}, wr_count, m_writes);
      check({tag, "_dones"}, done_count, m_dones);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, ObWriteAddress, 0);
      check({tag, "_data"}, ObData, 0);
      check({tag, "_write"}, OwWrite, 0);
      check({tag, "_disp"}, OwDisplayBank, 1);
      check({tag, "_valid"}, OwFrameValid, 0);
      check({tag, "_done"}, OwFrameDone, 0);
      check({tag, "_drop"}, ObDroppedFrames, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      m_reset();
      m_writes = 0;
      m_dones = 0;
      rst = 1'b1; dclk = 1'b0; hs = 1'b1; vs = 1'b1; pix = '0;
      tick(3);
      check_reset_outputs("reset");
      rst = 1'b0;
      tick(4);

      // DCLKs in IDLE and after VSYNC without HSYNC write nothing
      dclk_run(3);
      vs_pulse();
      dclk_run(3);
      check_status("no_hsync");

      // frame 1 into bank 0, first line constant pixel
      hs_pulse();
      for (int i = 0; i < H; i++) dclk_pulse(15'h1234, 1'b0);
      for (int l = 1; l < V; l++) begin
         hs_pulse();
         dclk_run(H);
      end
      check_status("frame1");

      // frame 2 into bank 1
      vs_pulse();
      for (int l = 0; l < V; l++) begin
         hs_pulse();
         dclk_run(H);
      end
      check_status("frame2");

      // short lines: 100 pixels, then random lengths, last line full
      vs_pulse();
      hs_pulse();
      dclk_run(100);
      hs_pulse();
      dclk_run($urandom_range(1, H - 1));
      hs_pulse();
      dclk_run($urandom_range(1, H - 1));
      hs_pulse();
      dclk_run(H);
      check_status("short");

      // early VSYNC mid-frame, then VSYNC coincident with a DCLK
      vs_pulse();
      hs_pulse();
      dclk_run(H);
      hs_pulse();
      dclk_run(H);
      hs_pulse();
      dclk_run(50);
      vs_pulse();
      check_status("abort");
      hs_pulse();
      dclk_run(5);
      dclk_pulse(15'($urandom), 1'b1);
      dclk_run(2);
      hs_pulse();
      dclk_run(4);
      check_status("vs_dclk");

      // drop counter saturation
      for (int i = 0; i < 260; i++) begin
         vs_pulse();
         check("drop_sat", ObDroppedFrames, m_drop);
      end

      // asynchronous reset mid-line
      hs_pulse();
      dclk_run(30);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("async_rst");
      m_reset();
      tick(2);
      rst = 1'b0;
      tick(2);
      dclk_run(3);
      hs_pulse();
      dclk_run(3);
      vs_pulse();
      hs_pulse();
      dclk_run(10);
      check_status("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
